// File: rtl/servo_pkg.sv
// servo_pkg: shared helpers and configuration bounds for servo_multi_drv.
// Holds clog2, microsecond-to-tick conversion and code-to-width scaling.
package servo_pkg;

  localparam int CH_MIN  = 1;
  localparam int CH_MAX  = 16;
  localparam int DAT_MIN = 4;
  localparam int DAT_MAX = 16;

  // Never returns less than 1 so that single-entry selects keep a port.
  function automatic int clog2(input longint n);
    int r;
    r = 0;
    for (int i = 0; i < 62; i++) begin
      if ((longint'(1) << i) < n) begin
        r = i + 1;
      end
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int ticks(
    input longint us,
    input longint fck
  );
    return int'(us * (fck / 1000) / 1000);
  endfunction

  function automatic int code_ticks(
    input int code,
    input int dat_w,
    input int bottom,
    input int top
  );
    longint prod;
    prod = longint'(code) * longint'(top - bottom);
    return bottom + int'(prod >> dat_w);
  endfunction

endpackage

// File: rtl/servo_multi_drv_if.sv
// servo_multi_drv_if: position write bus fanned out to every channel.
// The master side drives one word per cycle while wr is high.
interface servo_multi_drv_if #(
  parameter int CH_W  = 2,
  parameter int DAT_W = 8
);

  logic             wr;
  logic [CH_W-1:0]  ch;
  logic [DAT_W-1:0] dat;

  modport master (
    output wr,
    output ch,
    output dat
  );

  modport slave (
    input wr,
    input ch,
    input dat
  );

endinterface

// File: rtl/servo_ch.sv
// servo_ch: one channel's shadow/active width registers and pulse compare.
// Define SERVO_MULTI_SLEW_EN to rate-limit the active width per frame.
module servo_ch
  import servo_pkg::*;
#(
  parameter int W      = 15,
  parameter int CH_W   = 2,
  parameter int DAT_W  = 8,
  parameter int IDX    = 0,
  parameter int BOTTOM = 500,
  parameter int TOP    = 2400,
  parameter int SLEW   = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  servo_multi_drv_if.slave bus,
  input  logic             wrap,
  input  logic [W-1:0]     cnt,
  output logic             servo
);

  localparam int PW = DAT_W + W;

  localparam logic [W-1:0] MID =
    W'(code_ticks(1 << (DAT_W - 1), DAT_W, BOTTOM, TOP));
  localparam logic [W-1:0] BASE = W'(BOTTOM);
  localparam logic [W-1:0] SPAN = W'(TOP - BOTTOM);

  if (SLEW < 1) begin : g_bad_slew
    $error("servo_ch: slew step must be at least one tick");
  end

  logic          hit;
  logic [PW-1:0] prod;
  logic [W-1:0]  width;
  logic [W-1:0]  shadow;
  logic [W-1:0]  active;
  logic [W-1:0]  target;

  assign hit = bus.wr && (bus.ch == CH_W'(IDX));

  // Full-width product; the shifted result is always below SPAN.
  assign prod  = PW'(bus.dat) * PW'(SPAN);
  assign width = W'(PW'(BASE) + (prod >> DAT_W));

`ifdef SERVO_MULTI_SLEW_EN
  localparam logic [W-1:0] STEP = W'(SLEW);

  always_comb begin
    target = shadow;
    if (shadow > active) begin
      if (shadow - active > STEP) begin
        target = active + STEP;
      end
    end else if (active > shadow) begin
      if (active - shadow > STEP) begin
        target = active - STEP;
      end
    end
  end
`else
  assign target = shadow;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow <= MID;
      active <= MID;
      servo  <= 1'b0;
    end else begin
      if (hit) begin
        shadow <= width;
      end
      if (wrap) begin
        active <= target;
      end
      servo <= (cnt < active);
    end
  end

endmodule

// File: rtl/servo_multi_drv.sv
// servo_multi_drv: multi-channel servo pulse generator on a shared frame.
// Define SERVO_MULTI_SLEW_EN to enable per-frame slew limiting.
module servo_multi_drv
  import servo_pkg::*;
#(
  parameter int C_FCK     = 48_000_000,
  parameter int C_TFRAME  = 20_000,
  parameter int C_TBOTTOM = 500,
  parameter int C_TTOP    = 2_400,
  parameter int C_CH      = 4,
  parameter int C_DAT_W   = 8,
  parameter int C_SLEW    = 100
) (
  input  logic                     CK_i,
  input  logic                     XARST_i,
  input  logic                     WR_i,
  input  logic [clog2(C_CH)-1:0]   WR_CH_i,
  input  logic [C_DAT_W-1:0]       DAT_i,
  output logic [C_CH-1:0]          SERVO_o,
  output logic                     FRAME_o
);

  localparam int C_FRAME  = ticks(C_TFRAME, C_FCK);
  localparam int C_BOTTOM = ticks(C_TBOTTOM, C_FCK);
  localparam int C_TOP    = ticks(C_TTOP, C_FCK);
  localparam int W        = clog2(C_FRAME);
  localparam int CH_W     = clog2(C_CH);

  localparam logic [W-1:0] LAST  = W'(C_FRAME - 1);
  localparam logic [W-1:0] TOP_W = W'(C_TOP);

  if (!(C_BOTTOM < C_TOP && C_TOP < C_FRAME)) begin : g_bad_ticks
    $error("servo_multi_drv: need C_BOTTOM < C_TOP < C_FRAME");
  end

  if (C_CH < CH_MIN || C_CH > CH_MAX) begin : g_bad_ch
    $error("servo_multi_drv: channel count out of range");
  end

  if (C_DAT_W < DAT_MIN || C_DAT_W > DAT_MAX) begin : g_bad_dat
    $error("servo_multi_drv: code width out of range");
  end

  servo_multi_drv_if #(
    .CH_W  (CH_W),
    .DAT_W (C_DAT_W)
  ) bus ();

  assign bus.wr  = WR_i;
  assign bus.ch  = WR_CH_i;
  assign bus.dat = DAT_i;

  logic [W-1:0] cnt;
  logic         wrap;

  assign wrap = (cnt == LAST);

  // Outputs are registered from the pre-edge count, so count 0 is the
  // first high cycle of every frame.
  always_ff @(posedge CK_i) begin
    if (!XARST_i) begin
      cnt     <= '0;
      FRAME_o <= 1'b0;
    end else begin
      cnt     <= wrap ? '0 : cnt + 1'b1;
      FRAME_o <= (cnt < TOP_W);
    end
  end

  for (genvar n = 0; n < C_CH; n++) begin : g_ch
    servo_ch #(
      .W      (W),
      .CH_W   (CH_W),
      .DAT_W  (C_DAT_W),
      .IDX    (n),
      .BOTTOM (C_BOTTOM),
      .TOP    (C_TOP),
      .SLEW   (C_SLEW)
    ) u_ch (
      .clk   (CK_i),
      .rst_n (XARST_i),
      .bus   (bus),
      .wrap  (wrap),
      .cnt   (cnt),
      .servo (SERVO_o[n])
    );
  end

endmodule

// File: doc/servo_multi_drv.md
SERVO_MULTI_DRV -- requirements
Module: servo_multi_drv

Interface
REQ-001 SHALL have parameter C_FCK, 48_000_000, clock frequency [Hz].
REQ-002 SHALL have parameter C_TFRAME, 20_000, frame period [us].
REQ-003 SHALL have parameter C_TBOTTOM, 500, pulse width at code 0 [us].
REQ-004 SHALL have parameter C_TTOP, 2_400, full-scale pulse width and FRAME_o width [us].
REQ-005 SHALL have parameter C_CH, 4, channel count (1..16).
REQ-006 SHALL have parameter C_DAT_W, 8, position code width (4..16).
REQ-007 SHALL have parameter C_SLEW, 100, max width change per frame [ticks] (used only with slew feature).
REQ-008 SHALL have port CK_i  in  1  sole clock, rising edge.
REQ-009 SHALL have port XARST_i  in  1  reset, synchronous, active-low.
REQ-010 SHALL have port WR_i  in  1  write strobe, one word per high cycle.
REQ-011 SHALL have port WR_CH_i  in  clog2(C_CH) (min 1)  target channel.
REQ-012 SHALL have port DAT_i  in  C_DAT_W  position code.
REQ-013 SHALL have port SERVO_o  out  C_CH  per-channel pulse outputs.
REQ-014 SHALL have port FRAME_o  out  1  frame marker.

Function
REQ-015 Tick constants SHALL be C_FRAME=C_TFRAME*(C_FCK/1000)/1000, C_BOTTOM and C_TOP likewise, computed at elaboration; C_BOTTOM<C_TOP<C_FRAME is checked at elaboration.
REQ-016 Frame counter SHALL count 0..C_FRAME-1 and wrap to 0; width clog2(C_FRAME).
REQ-017 On WR_i=1 with WR_CH_i<C_CH, shadow[WR_CH_i] SHALL load C_BOTTOM+((DAT_i*(C_TOP-C_BOTTOM))>>C_DAT_W), full-precision product, no overflow.
REQ-018 Writes with WR_CH_i>=C_CH SHALL be ignored, no side effect.
REQ-019 In the cycle the counter wraps to 0, active[n] SHALL load target for every channel (shadow, or slewed value per REQ-029); a write in that same cycle updates shadow only and takes effect next frame.
REQ-020 SERVO_o[n] SHALL be registered, high for exactly active[n] consecutive cycles starting the first cycle of each frame, low for the rest of the frame.
REQ-021 FRAME_o SHALL be registered, high for exactly C_TOP cycles starting the first cycle of each frame.
REQ-022 All channels SHALL rise in the same cycle as FRAME_o; no glitches between frames.
REQ-023 Writes SHALL be accepted every cycle; no busy/backpressure; back-to-back writes to one channel keep the last.

Reset
REQ-024 With XARST_i=0 at a clock edge: counter=0, SERVO_o=0, FRAME_o=0, every shadow and active = width of code 2^(C_DAT_W-1).
REQ-025 First frame SHALL start (SERVO_o and FRAME_o high) on the first edge after XARST_i sampled 1.
REQ-026 Reset mid-frame SHALL truncate the pulse at the next edge and discard pending shadow writes.

Configuration
REQ-027 Macro SERVO_MULTI_SLEW_EN SHALL select slew limiting.
REQ-028 Without it: target = shadow; frame-to-frame width may jump arbitrarily.
REQ-029 With it: target = active moved toward shadow by min(|shadow-active|, C_SLEW) ticks per frame; equal when reached; no overshoot.

Structure
REQ-030 Package servo_pkg SHALL hold the clog2 function, tick-conversion function and C_DAT_W/C_CH bounds.
REQ-031 Per-channel logic (shadow, active, slew, comparator) SHALL be sub-module servo_ch, instantiated C_CH times; frame counter stays in top.

Verification (C_FCK=1_000_000, C_CH=4, C_DAT_W=8, defaults otherwise: C_FRAME=20000, C_BOTTOM=500, C_TOP=2400)
REQ-032 Release reset, no writes -> every frame all SERVO_o high 1450 cycles, FRAME_o high 2400, period 20000.
REQ-033 Write ch0=0, ch3=255 mid-frame -> current frame unchanged; next frame ch0=500, ch3=2392, ch1/ch2=1450.
REQ-034 Write ch2=64 in wrap cycle -> ch2 stays 1450 in new frame, 975 in following frame; write WR_CH_i=5 (C_CH=4, 3-bit port forced) -> no change.
REQ-035 SERVO_MULTI_SLEW_EN, ch1 1450 then write 255 -> widths 1550,1650,...,2350,2392 on successive frames.
REQ-036 Assert XARST_i=0 at counter 700 -> outputs 0 next edge; after release widths return to 1450 regardless of prior writes.
